// File: rtl/rv_pkg.sv
// rv_pkg
// Shared definitions for the front end of the core: datapath widths, the
// canonical NOP encoding, the default reset PC and the layout of one fetch
// buffer entry. The fault helper lives here so any stage that needs to
// classify a fetch address applies the same rule.
package rv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // addi x0, x0, 0 -- substituted for the instruction of any faulted fetch
    localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0;

    // One fetch buffer entry: address, instruction word, fault flag
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            fault;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // A fetch faults when the address lies above the ROM window or is not
    // word aligned
    function automatic logic fetch_fault(input logic [XLEN-1:0] pc, input int rom_aw);
        return ((pc >> rom_aw) != '0) || (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Small synchronous FIFO holding fetched {pc, inst, fault} entries between
// the fetch and decode stages. Push and pop may happen in the same cycle,
// including when the FIFO is full, so the fetch stage sustains one entry per
// cycle. Flush empties the FIFO on the next edge and wins over push/pop.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      discard all entries and reset pointers
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        advance the head (caller only pops when count != 0)
//   head_data  entry at the head (meaningful when count != 0)
//   count      number of valid entries, 0..DEPTH
module fetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [ENTRY_W-1:0]         push_data,
    input  logic                       pop,
    output logic [ENTRY_W-1:0]         head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count_next;

    // Occupancy after this cycle's push/pop; a simultaneous push and pop
    // leaves it unchanged
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointers and count; DEPTH is a power of two so the pointers wrap
    // naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
        end
    end

    // Storage needs no reset: nothing reads it while count is zero
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch: owns the PC, drives the zero-latency instruction ROM,
// captures {pc, instruction, fault} into a small buffer and hands entries to
// decode over a valid/ready handshake. Redirects from later stages flush the
// buffer and reload the PC.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   fetch_en        1 = fetch allowed; 0 = PC holds while buffer drains
//   im_addr         byte address to the ROM (the PC register)
//   im_dout         ROM word for im_addr, same cycle
//   redirect_valid  flush buffer and load redirect_pc (highest priority)
//   redirect_pc     redirect target, used unaligned as given
//   id_valid        buffer head valid
//   id_ready        decode accepts the head this cycle
//   id_pc           PC of head entry
//   id_inst         instruction of head entry (NOP if faulted)
//   id_fault        head was out of ROM range or misaligned
module fetch_stage
    import rv_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2,
    parameter int          ROM_AW   = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [63:0] im_addr,
    input  logic [31:0] im_dout,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [63:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_fault
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]    pc;
    logic [CW-1:0]      fifo_count;
    logic [ENTRY_W-1:0] head_bits;
    fetch_entry_t       head;
    fetch_entry_t       new_entry;
    logic               deq;
    logic               enq;
    logic               fault;

    assign im_addr = pc;

    // A full buffer still accepts a new entry when the head leaves in the
    // same cycle; a redirect suppresses fetch entirely
    assign deq = id_valid & id_ready;
    assign enq = fetch_en & ~redirect_valid & ((fifo_count != CW'(DEPTH)) | deq);

    // Faulted fetches carry a NOP so a bogus ROM word never reaches decode
    always_comb begin
        fault          = fetch_fault(pc, ROM_AW);
        new_entry.pc   = pc;
        new_entry.inst = fault ? INST_NOP : im_dout;
        new_entry.fault = fault;
    end

    // PC register: redirect beats sequential advance; it only moves when
    // an instruction was actually captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (enq) begin
            pc <= pc + 64'd4;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (enq),
        .push_data (new_entry),
        .pop       (deq),
        .head_data (head_bits),
        .count     (fifo_count)
    );

    assign head = fetch_entry_t'(head_bits);

    // Head fields are forced to zero while empty so reset (which is
    // asynchronous) clears them without resetting the storage array
    assign id_valid = (fifo_count != '0);
    assign id_pc    = id_valid ? head.pc    : '0;
    assign id_inst  = id_valid ? head.inst  : '0;
    assign id_fault = id_valid ? head.fault : 1'b0;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage that drives the instruction ROM and feeds the decode stage.
- Holds the PC, presents it to the ROM's combinational read port, and captures {pc, instruction} each cycle into a small fetch buffer.
- Hands buffer entries to decode over a valid/ready handshake.
- Accepts redirects (branch, jump, trap) from later stages.
- The ROM has zero read latency, so one instruction per cycle is sustained while decode accepts.

Parameters:
RESET_PC, 64'h0, PC value loaded at reset
DEPTH, 2, fetch buffer entries (power of 2, ≥2)
ROM_AW, 14, byte-address bits covered by the ROM; pc[63:ROM_AW]!=0 is out of range

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
fetch_en  input  1  1 = fetching allowed; 0 = PC holds, buffer still drains
im_addr  output  64  byte address to ROM; always equals pc register
im_dout  input  32  instruction word from ROM, same cycle as im_addr
redirect_valid  input  1  flush and load new PC
redirect_pc  input  64  redirect target
id_valid  output  1  buffer head valid
id_ready  input  1  decode accepts head this cycle
id_pc  output  64  PC of head entry
id_inst  output  32  instruction of head entry
id_fault  output  1  head fetched out of ROM range or misaligned

Behaviour:
Reset (async, while rst=1):
- pc=RESET_PC
- buffer count=0; rd/wr pointers 0
- id_valid=0, id_pc=0, id_inst=0, id_fault=0

Definitions:
- deq = id_valid & id_ready
- enq = fetch_en & ~redirect_valid & (count<DEPTH | deq)
- Full buffer with a simultaneous dequeue still enqueues, giving 1/cycle throughput at DEPTH.

Fetch (on enq):
- Write {pc, im_dout, fault} at wr_ptr.
- pc <= pc+4, 64-bit wrap, no overflow detection.
- fault = (pc[63:ROM_AW]!=0) | (pc[1:0]!=0).
- Faulted entries store inst=32'h00000013 (NOP) in place of im_dout.

Dequeue (on deq):
- Advance rd_ptr.
- Count update: count += enq − deq.

Redirect (redirect_valid=1, highest priority):
- Next edge: count=0, pointers reset, pc<=redirect_pc.
- No enqueue that cycle.
- Head is discarded regardless of id_ready; decode ignores id_valid in a redirect cycle.
- redirect_pc is not realigned. A misaligned target is fetched and flagged via fault.

Outputs:
- id_pc/id_inst/id_fault come from the buffer head.
- id_valid=(count!=0).
- Registered state only; no combinational path from im_dout to id_*.

Other rules:
- fetch_en=0: pc and enqueue frozen; dequeues proceed.
- Latency: instruction at pc visible on id_* the cycle after the enqueue edge (1 cycle after reset release or redirect).
- id_* hold stable while id_valid=1 & id_ready=0.

Decomposition:
- Shared package rv_pkg: XLEN=64, ILEN=32, INST_NOP=32'h00000013, RESET_PC default.
- Sub-module fetch_fifo: parameterised DEPTH × (64+32+1) synchronous FIFO with flush, count, simultaneous push/pop.
- fetch_stage owns the PC, enq/fault logic and redirect priority.

Test Plan:
- Reset, then fetch_en=1, id_ready=1, ROM words 0..3 = A,B,C,D → id_valid rises 1 cycle after reset release; id_pc 0,4,8,C with insts A,B,C,D on consecutive cycles.
- id_ready=0 for 5 cycles → buffer fills to 2, pc stops at 8, head stays pc=0/inst=A. Release → 0,4,8 delivered back-to-back with no bubble.
- Redirect to 0x100 while buffer full and id_ready=1 → next cycle id_valid=0; following cycle id_pc=0x100, id_inst=ROM[64]. Old entries never appear.
- Redirect to 0x4000 (ROM_AW=14) → id_pc=0x4000, id_fault=1, id_inst=0x00000013.
- Redirect to 0x102 → id_fault=1; next entry pc=0x106, also faulted.
- rst asserted mid-stream between edges → outputs clear immediately, not at the next edge. After release, fetch restarts at RESET_PC.
